// File: rtl/line_sched_pkg.sv
// Shared types and helpers for the rotating three-RAM line-buffer sequencer.
package line_sched_pkg;

    localparam int NUM_LINE_RAM = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL0 = 3'd1,
        FILL1 = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    // One-hot write enable for RAM index 0/1/2; index 3 is never produced.
    function automatic logic [NUM_LINE_RAM-1:0] onehot3(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Next RAM in the rotation a -> b -> c -> a.
    function automatic logic [1:0] rot_next(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/line_buf_sched_sig_edge.sv
// sig_edge: registers a level and flags its rising and falling edges.
// The edge flags are combinational against the registered copy, so they
// are high in the first cycle the input differs from its previous value.
module sig_edge (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    // Delay the input by one cycle for edge comparison.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!rstn) d_q <= 1'b0;
        else       d_q <= d;
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/line_buf_sched.sv
// line_buf_sched: sequencer for the three-RAM rotating line buffer.
// Tracks active lines from de/vsync, owns the write rotation pointer,
// decodes which RAMs hold rows y-1 / y-2, flags when a full 3-row window
// is available and checks line length and line count.
// Optional build macro: LINE_SCHED_BORDER_EN (top-border replication:
// the window starts on line 1 with row 0 standing in for row y-2).
module line_buf_sched
    import line_sched_pkg::*;
#(
    parameter logic [11:0] H_ACT = 12'd1280,
    parameter logic [11:0] V_ACT = 12'd720
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      hsync,
    input  logic                      vsync,
    input  logic                      de,
    output logic [NUM_LINE_RAM-1:0]   wen,
    output logic [1:0]                sel_up,
    output logic [1:0]                sel_up2,
    output logic                      row_valid,
    output logic [$clog2(V_ACT)-1:0]  line_cnt,
    output logic                      frame_done,
    output logic                      len_err
);

    localparam int                  LINE_W    = $clog2(V_ACT);
    localparam int                  PIX_W     = $clog2(H_ACT + 2);
    localparam logic [LINE_W-1:0]   LAST_LINE = LINE_W'(V_ACT - 12'd1);
    localparam logic [PIX_W-1:0]    H_LEN     = PIX_W'(H_ACT);

    sched_state_t        state, state_n;
    logic [1:0]          wptr, wptr_n;
    logic [LINE_W-1:0]   line_cnt_n;
    logic [PIX_W-1:0]    pix_cnt, pix_cnt_n, pix_inc;
    logic                len_err_n, frame_done_n;
    logic                seen_vsync;
    logic                blocked;
    logic                de_fall, vs_rise;
    logic                unused_de_rise, unused_vs_fall, unused_hsync;

    // Line boundaries come from de alone; hsync carries no timing we need.
    assign unused_hsync = hsync;

    sig_edge u_de_edge (
        .clk  (clk),
        .rstn (rstn),
        .d    (de),
        .rise (unused_de_rise),
        .fall (de_fall)
    );

    sig_edge u_vs_edge (
        .clk  (clk),
        .rstn (rstn),
        .d    (vsync),
        .rise (vs_rise),
        .fall (unused_vs_fall)
    );

    // After reset the frame position is unknown, so nothing is written until
    // a vsync has been observed; after the last line writes stop until vsync.
    assign blocked = (state == DONE) || ((state == IDLE) && !seen_vsync);

    assign pix_inc = (pix_cnt == '1) ? pix_cnt : pix_cnt + PIX_W'(1);

    // Output decode from the registered rotation pointer.
    assign wen    = (de && !blocked) ? onehot3(wptr) : '0;
    assign sel_up = rot_next(rot_next(wptr));
`ifdef LINE_SCHED_BORDER_EN
    assign sel_up2   = (state == FILL1) ? sel_up : rot_next(wptr);
    assign row_valid = de && ((state == RUN) || (state == FILL1));
`else
    assign sel_up2   = rot_next(wptr);
    assign row_valid = de && (state == RUN);
`endif

    // Latch the first vsync seen after reset; it stays set until the next reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        seen_vsync <= 1'b0;
        else if (vs_rise) seen_vsync <= 1'b1;
    end

    // Next-state logic: vsync restart beats everything, then line-end handling.
    always_comb begin
        // NOTE: every variable gets a default up front so no path through
        // the block leaves a value unassigned and infers a latch.
        state_n      = state;
        wptr_n       = wptr;
        line_cnt_n   = line_cnt;
        pix_cnt_n    = pix_cnt;
        len_err_n    = 1'b0;
        frame_done_n = 1'b0;

        if (vsync) begin
            state_n    = IDLE;
            wptr_n     = 2'd0;
            line_cnt_n = '0;
            pix_cnt_n  = '0;
        end else begin
            if (de && !blocked) pix_cnt_n = pix_inc;

            case (state)
                IDLE: begin
                    if (de && seen_vsync) state_n = FILL0;
                end
                FILL0, FILL1, RUN: begin
                    if (de_fall) begin
                        // A wrong-length line is flagged but still consumed.
                        pix_cnt_n = '0;
                        wptr_n    = rot_next(wptr);
                        len_err_n = (pix_cnt != H_LEN);
                        if (line_cnt != LAST_LINE) line_cnt_n = line_cnt + LINE_W'(1);
                        if (state == FILL0) begin
                            state_n = FILL1;
                        end else if (state == FILL1) begin
                            state_n = RUN;
                        end else if (line_cnt == LAST_LINE) begin
                            state_n      = DONE;
                            frame_done_n = 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Extra lines past the frame are reported, never written.
                    if (de_fall) len_err_n = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Sequencer state registers and registered status pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            wptr       <= 2'd0;
            line_cnt   <= '0;
            pix_cnt    <= '0;
            len_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            wptr       <= wptr_n;
            line_cnt   <= line_cnt_n;
            pix_cnt    <= pix_cnt_n;
            len_err    <= len_err_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_line_buf_sched.sv
// Directed, table-driven bench for line_buf_sched with a small frame
// (8 pixels x 12 lines) so whole frames fit in a short run.
module tb_line_buf_sched;

    localparam logic [11:0] H = 12'd8;
    localparam logic [11:0] V = 12'd12;

`ifdef LINE_SCHED_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       hsync, vsync, de;
    logic [2:0] wen;
    logic [1:0] sel_up, sel_up2;
    logic       row_valid;
    logic [3:0] line_cnt;
    logic       frame_done, len_err;

    int n_vec   = 0;
    int n_bad   = 0;
    int fd_seen = 0;

    typedef struct {
        int         n_de;
        logic [2:0] wen;
        logic [1:0] up;
        logic [1:0] up2;
        logic       rv;
        logic [3:0] lc;
        logic       le;
        logic       fd;
    } line_vec_t;

    line_vec_t tbl[13];

    line_buf_sched #(.H_ACT(H), .V_ACT(V)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .wen        (wen),
        .sel_up     (sel_up),
        .sel_up2    (sel_up2),
        .row_valid  (row_valid),
        .line_cnt   (line_cnt),
        .frame_done (frame_done),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs just after the edge, leave outputs to settle.
    task automatic step(input logic v, input logic d);
        @(posedge clk);
        #1;
        vsync = v;
        de    = d;
        hsync = ~d;
        #1;
        if (frame_done === 1'b1) fd_seen++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wen"},      32'(wen),        32'h0);
        check({tag, "_rv"},       32'(row_valid),  32'h0);
        check({tag, "_lc"},       32'(line_cnt),   32'h0);
        check({tag, "_sel_up"},   32'(sel_up),     32'h2);
        check({tag, "_sel_up2"},  32'(sel_up2),    32'h1);
        check({tag, "_len_err"},  32'(len_err),    32'h0);
        check({tag, "_fd"},       32'(frame_done), 32'h0);
    endtask

    // Play one line from the table and compare every de cycle plus the pulses.
    task automatic play(input int idx);
        line_vec_t v;
        v = tbl[idx];
        for (int k = 0; k < v.n_de; k++) begin
            step(1'b0, 1'b1);
            check($sformatf("l%0d_wen", idx),     32'(wen),       32'(v.wen));
            check($sformatf("l%0d_sel_up", idx),  32'(sel_up),    32'(v.up));
            check($sformatf("l%0d_sel_up2", idx), 32'(sel_up2),   32'(v.up2));
            check($sformatf("l%0d_rv", idx),      32'(row_valid), 32'(v.rv));
            check($sformatf("l%0d_lc", idx),      32'(line_cnt),  32'(v.lc));
        end
        step(1'b0, 1'b0);
        check($sformatf("l%0d_fall_wen", idx), 32'(wen),       32'h0);
        check($sformatf("l%0d_fall_rv", idx),  32'(row_valid), 32'h0);
        step(1'b0, 1'b0);
        check($sformatf("l%0d_len_err", idx), 32'(len_err),    32'(v.le));
        check($sformatf("l%0d_fd", idx),      32'(frame_done), 32'(v.fd));
        step(1'b0, 1'b0);
        check($sformatf("l%0d_len_err_off", idx), 32'(len_err),    32'h0);
        check($sformatf("l%0d_fd_off", idx),      32'(frame_done), 32'h0);
    endtask

    task automatic do_vsync();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        //             n_de wen     up     up2                  rv      lc     le    fd
        tbl[0]  = '{8, 3'b001, 2'd2, 2'd1,                1'b0,   4'd0,  1'b0, 1'b0};
        tbl[1]  = '{8, 3'b010, 2'd0, BORDER ? 2'd0 : 2'd2, BORDER, 4'd1,  1'b0, 1'b0};
        tbl[2]  = '{8, 3'b100, 2'd1, 2'd0,                1'b1,   4'd2,  1'b0, 1'b0};
        tbl[3]  = '{8, 3'b001, 2'd2, 2'd1,                1'b1,   4'd3,  1'b0, 1'b0};
        tbl[4]  = '{8, 3'b010, 2'd0, 2'd2,                1'b1,   4'd4,  1'b0, 1'b0};
        tbl[5]  = '{7, 3'b100, 2'd1, 2'd0,                1'b1,   4'd5,  1'b1, 1'b0};
        tbl[6]  = '{8, 3'b001, 2'd2, 2'd1,                1'b1,   4'd6,  1'b0, 1'b0};
        tbl[7]  = '{8, 3'b010, 2'd0, 2'd2,                1'b1,   4'd7,  1'b0, 1'b0};
        tbl[8]  = '{8, 3'b100, 2'd1, 2'd0,                1'b1,   4'd8,  1'b0, 1'b0};
        tbl[9]  = '{8, 3'b001, 2'd2, 2'd1,                1'b1,   4'd9,  1'b0, 1'b0};
        tbl[10] = '{8, 3'b010, 2'd0, 2'd2,                1'b1,   4'd10, 1'b0, 1'b0};
        tbl[11] = '{8, 3'b100, 2'd1, 2'd0,                1'b1,   4'd11, 1'b0, 1'b1};
        tbl[12] = '{8, 3'b000, 2'd2, 2'd1,                1'b0,   4'd11, 1'b1, 1'b0};

        // Reset with de held high: nothing may be written.
        rstn  = 1'b0;
        vsync = 1'b0;
        de    = 1'b1;
        hsync = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rstn = 1'b1;

        // No vsync seen yet: de is ignored and the partial line raises nothing.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1);
            check("pre_vsync_wen", 32'(wen), 32'h0);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("pre_vsync_len_err", 32'(len_err), 32'h0);

        // Full frame plus one extra line.
        do_vsync();
        fd_seen = 0;
        for (int i = 0; i < 13; i++) play(i);
        check("frame_done_count", 32'(fd_seen), 32'd1);

        // Restart; vsync lands on the de fall of line 3 in RUN.
        do_vsync();
        for (int i = 0; i < 3; i++) play(i);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1);
            check("l3v_wen", 32'(wen), 32'h1);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("vs_fall_len_err", 32'(len_err),  32'h0);
        check("vs_fall_lc",      32'(line_cnt), 32'h0);
        check("vs_fall_sel_up",  32'(sel_up),   32'h2);
        check("vs_fall_fd",      32'(frame_done), 32'h0);
        step(1'b0, 1'b0);
        check("vs_fall_len_err2", 32'(len_err), 32'h0);
        // Restarted from IDLE: line 0 writes RAM a, line 1 is FILL1.
        for (int i = 0; i < 10; i++) play(i);

        // Reset pulse in the middle of line 10.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1);
            check("l10_wen", 32'(wen), 32'h2);
        end
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("midline_reset");
        step(1'b0, 1'b1);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1);
            check("post_rst_wen", 32'(wen), 32'h0);
            check("post_rst_rv",  32'(row_valid), 32'h0);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("post_rst_len_err", 32'(len_err), 32'h0);
        // A full line before vsync is still ignored.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1);
            check("no_vsync_wen", 32'(wen), 32'h0);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("no_vsync_len_err", 32'(len_err),  32'h0);
        check("no_vsync_lc",      32'(line_cnt), 32'h0);
        do_vsync();
        play(0);
        play(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
